// File: rtl/ts_queue_bank_n.sv
// ts_queue_bank_n: bank of N timestamped FIFOs presenting head timestamps/valids to an
// earliest-first selector and popping the queue the selector names.
`default_nettype none

module ts_queue_bank_n #(
  parameter int N      = 4,
  parameter int WIDTH  = 3,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  localparam int LOG_N = (N > 1) ? $clog2(N) : 1,
  localparam int LOG_D = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enq_valid,
  input  logic [LOG_N-1:0]     enq_port,
  input  logic [WIDTH-1:0]     enq_ts,
  input  logic [DWIDTH-1:0]    enq_data,
  output logic                 enq_ready,
  output logic [N-1:0]         full,
  output logic [N*WIDTH-1:0]   head_ts,
  output logic [N-1:0]         head_valid,
  input  logic                 deq_en,
  input  logic [LOG_N-1:0]     deq_sel,
  output logic                 deq_valid,
  output logic [WIDTH-1:0]     deq_ts,
  output logic [DWIDTH-1:0]    deq_data,
  output logic                 deq_err
);

  localparam int NP = 2 ** LOG_N;
  // Ports that decode to an existing queue; indices >= N read as 0.
  localparam logic [NP-1:0] PORT_MASK = NP'((64'd1 << N) - 64'd1);

  logic [WIDTH+DWIDTH-1:0] mem [N][DEPTH];
  logic [LOG_D:0]          rd_ptr [N];
  logic [LOG_D:0]          wr_ptr [N];

  logic [NP-1:0]     full_ext;
  logic [NP-1:0]     valid_ext;
  logic [WIDTH-1:0]  head_ts_ext   [NP];
  logic [DWIDTH-1:0] head_data_ext [NP];

  logic enq_fire;
  logic deq_fire;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      full_ext[i]      = 1'b0;
      valid_ext[i]     = 1'b0;
      head_ts_ext[i]   = '0;
      head_data_ext[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      valid_ext[i] = (rd_ptr[i] != wr_ptr[i]);
      full_ext[i]  = (rd_ptr[i][LOG_D] != wr_ptr[i][LOG_D]) &&
                     (rd_ptr[i][LOG_D-1:0] == wr_ptr[i][LOG_D-1:0]);
      if (rd_ptr[i] != wr_ptr[i]) begin
        {head_ts_ext[i], head_data_ext[i]} = mem[i][rd_ptr[i][LOG_D-1:0]];
      end
    end
  end

  assign enq_ready  = PORT_MASK[enq_port] && !full_ext[enq_port];
  assign enq_fire   = enq_valid && enq_ready;
  assign deq_fire   = deq_en && PORT_MASK[deq_sel] && valid_ext[deq_sel];
  assign full       = full_ext[N-1:0];
  assign head_valid = valid_ext[N-1:0];

  for (genvar g = 0; g < N; g++) begin : g_head
    assign head_ts[g*WIDTH +: WIDTH] = head_ts_ext[g];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      deq_valid <= 1'b0;
      deq_err   <= 1'b0;
      deq_ts    <= '0;
      deq_data  <= '0;
    end else begin
      deq_valid <= deq_fire;
      deq_err   <= deq_en && !deq_fire;
      if (deq_fire) begin
        deq_ts   <= head_ts_ext[deq_sel];
        deq_data <= head_data_ext[deq_sel];
      end
      for (int i = 0; i < N; i++) begin
        if (enq_fire && (enq_port == LOG_N'(i))) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq_fire && (deq_sel == LOG_N'(i)))  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; pointers alone define live contents.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (enq_fire && (enq_port == LOG_N'(i))) begin
        mem[i][wr_ptr[i][LOG_D-1:0]] <= {enq_ts, enq_data};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ts_queue_bank_n.sv
// Self-checking bench for ts_queue_bank_n against a queue-based reference model.
`default_nettype none

module tb_ts_queue_bank_n;
  localparam int N  = 4;
  localparam int W  = 3;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enq_valid = 1'b0;
  logic [1:0]    enq_port = '0;
  logic [W-1:0]  enq_ts = '0;
  logic [DW-1:0] enq_data = '0;
  logic          enq_ready;
  logic [N-1:0]  full;
  logic [N*W-1:0] head_ts;
  logic [N-1:0]  head_valid;
  logic          deq_en = 1'b0;
  logic [1:0]    deq_sel = '0;
  logic          deq_valid;
  logic [W-1:0]  deq_ts;
  logic [DW-1:0] deq_data;
  logic          deq_err;

  ts_queue_bank_n #(.N(N), .WIDTH(W), .DWIDTH(DW), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_port(enq_port), .enq_ts(enq_ts), .enq_data(enq_data),
    .enq_ready(enq_ready), .full(full), .head_ts(head_ts), .head_valid(head_valid),
    .deq_en(deq_en), .deq_sel(deq_sel), .deq_valid(deq_valid), .deq_ts(deq_ts),
    .deq_data(deq_data), .deq_err(deq_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [W+DW-1:0] mq [N][$];
  logic [W-1:0]    exp_dts = '0;
  logic [DW-1:0]   exp_dd  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Earliest head under modulo-2^W comparison; ties go to the lowest port.
  function automatic int pick();
    int best = -1;
    logic [W-1:0] hb, hi, d;
    logic [W+DW-1:0] e;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        e  = mq[i][0];
        hi = e[W+DW-1:DW];
        if (best < 0) begin
          best = i;
          hb   = hi;
        end else begin
          d = hb - hi;
          if (d != 0 && d < W'(1 << (W - 1))) begin
            best = i;
            hb   = hi;
          end
        end
      end
    end
    return (best < 0) ? 0 : best;
  endfunction

  task automatic check_comb();
    logic [N-1:0]   ehv, efull;
    logic [N*W-1:0] eht;
    logic [W+DW-1:0] e;
    ehv = '0; efull = '0; eht = '0;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        e = mq[i][0];
        ehv[i] = 1'b1;
        eht[i*W +: W] = e[W+DW-1:DW];
      end
      efull[i] = (mq[i].size() == D);
    end
    chk("head_valid", 32'(head_valid), 32'(ehv));
    chk("head_ts", 32'(head_ts), 32'(eht));
    chk("full", 32'(full), 32'(efull));
    chk("enq_ready", 32'(enq_ready), 32'(mq[enq_port].size() < D));
  endtask

  task automatic step(input logic ev, input int ep, input int ets, input int ed,
                      input logic de, input int ds);
    bit eok, dok;
    logic [W+DW-1:0] pe;
    enq_valid = ev;
    enq_port  = ep[1:0];
    enq_ts    = ets[W-1:0];
    enq_data  = ed[DW-1:0];
    deq_en    = de;
    deq_sel   = ds[1:0];
    #1;
    check_comb();
    eok = ev && (mq[ep].size() < D);
    dok = de && (mq[ds].size() > 0);
    if (dok) begin
      pe = mq[ds].pop_front();
      exp_dts = pe[W+DW-1:DW];
      exp_dd  = pe[DW-1:0];
    end
    if (eok) mq[ep].push_back({ets[W-1:0], ed[DW-1:0]});
    @(posedge clock);
    #1;
    chk("deq_valid", 32'(deq_valid), 32'(dok));
    chk("deq_err", 32'(deq_err), 32'(de && !dok));
    chk("deq_ts", 32'(deq_ts), 32'(exp_dts));
    chk("deq_data", 32'(deq_data), 32'(exp_dd));
    enq_valid = 1'b0;
    deq_en    = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state and idle cycle
    step(0, 0, 0, 0, 0, 0);

    // Single entry on port 1, popped via selector choice
    step(1, 1, 2, 'hA1, 0, 0);
    step(0, 0, 0, 0, 1, pick());
    step(0, 0, 0, 0, 0, 0);

    // Fill port 3, overflow attempt dropped, drain in order
    for (int t = 0; t < 4; t++) step(1, 3, t, 'h30 + t, 0, 0);
    step(1, 3, 4, 'h34, 0, 0);
    for (int t = 0; t < 4; t++) step(0, 0, 0, 0, 1, 3);

    // Interleaved enq/deq on port 0 wrapping the pointers
    for (int k = 0; k < 10; k++) begin
      step(1, 0, k % 8, 'h50 + k, 0, 0);
      step(0, 0, 0, 0, 1, 0);
    end

    // Same-cycle enq+deq: non-empty queue, then empty queue
    step(1, 2, 5, 'h25, 0, 0);
    step(1, 2, 6, 'h26, 1, 2);
    step(1, 1, 7, 'h17, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    // Full queue: deq happens, enq rejected
    for (int t = 0; t < 3; t++) step(1, 3, t, 'h60 + t, 0, 0);
    step(1, 3, 3, 'h63, 0, 0);
    step(1, 3, 4, 'h64, 1, 3);
    for (int t = 0; t < 3; t++) step(0, 0, 0, 0, 1, 3);

    // Wrap-around selection: heads 6 (p0), 7 (p1), 0 (p2)
    step(0, 0, 0, 0, 1, 2);
    step(1, 0, 6, 'h06, 0, 0);
    step(1, 2, 0, 'h20, 0, 0);
    step(0, 0, 0, 0, 1, pick());
    step(0, 0, 0, 0, 1, pick());

    // Asynchronous reset mid-operation discards everything
    step(1, 0, 1, 'h01, 1, pick());
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_dts = '0;
    exp_dd  = '0;
    chk("rst_head_valid", 32'(head_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_deq_err", 32'(deq_err), 32'd0);
    chk("rst_deq_ts", 32'(deq_ts), 32'd0);
    chk("rst_deq_data", 32'(deq_data), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
